// File: rtl/bitstream_feeder_pkg.sv
// Shared constants and types for the arithmetic-decoder front end.
package bitstream_feeder_pkg;

  // Stream granularity and default input buffering for the feeder.
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Arithmetic decoder constants.
  localparam int unsigned RANGE_W      = 9;
  localparam int unsigned OFFSET_W     = 9;
  localparam int unsigned RANGE_INIT   = 510;
  localparam int unsigned RENORM_LIMIT = 256;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO: storage array, head/tail pointers and occupancy.
// Callers present push_i/pop_i already qualified against full/empty.
module byte_fifo
  import bitstream_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  byte_t           wdata_i,
  output byte_t           rdata_o,
  output logic [LvlW-1:0] level_o
);

  byte_t           mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [LvlW-1:0] level_q, level_d;

  // Next-state for pointers and occupancy; clear dominates push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign level_o = level_q;

endmodule

// File: rtl/bitstream_feeder.sv
// Feeds bitstream bytes to the arithmetic decoder through a small FIFO,
// flagging stalls, sticky underflow and counting consumed bytes.
module bitstream_feeder
  import bitstream_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  byte_t            in_data_i,
  output logic             in_ready_o,
  input  logic             request_byte_i,
  output byte_t            data_o,
  output logic             data_valid_o,
  output logic             stall_o,
  output logic             underflow_o,
  output logic [CNT_W-1:0] bytes_consumed_o,
  output logic [LvlW-1:0]  level_o
);

  logic [LvlW-1:0]  level;
  byte_t            head_data;
  logic             push, pop;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] count_q, count_d;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data_i),
    .rdata_o (head_data),
    .level_o (level)
  );

  // Handshake and presentation depend only on registered occupancy.
  always_comb begin
    in_ready_o   = (level != LvlW'(DEPTH));
    data_valid_o = (level != '0);
    data_o       = data_valid_o ? head_data : '0;
    stall_o      = request_byte_i && !data_valid_o;
    push         = in_valid_i && in_ready_o && !flush_i;
    pop          = request_byte_i && data_valid_o && !flush_i;
  end

  // Sticky underflow and wrapping consumed-byte count, both cleared by flush.
  always_comb begin
    underflow_d = underflow_q | stall_o;
    count_d     = pop ? count_q + CNT_W'(1) : count_q;
    if (flush_i) begin
      underflow_d = 1'b0;
      count_d     = '0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      underflow_q <= underflow_d;
      count_q     <= count_d;
    end
  end

  assign underflow_o      = underflow_q;
  assign bytes_consumed_o = count_q;
  assign level_o          = level;

endmodule
